// File: rtl/axist_h2h_pkg.sv
// Shared definitions for the AXI-ST host-to-host link model: register map,
// generator modes, LFSR polynomial and the 256-bit beat type.
package axist_h2h_pkg;

    localparam int LANES = 8;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [31:0] ADDR_TX_PKT_CTRL = 32'h5000_1000;
    localparam logic [31:0] ADDR_RX_CKR_STS  = 32'h5000_1004;
    localparam logic [31:0] ADDR_LINKUP      = 32'h5000_1008;
    localparam logic [31:0] ADDR_DELAY_X     = 32'h5000_2000;
    localparam logic [31:0] ADDR_DELAY_Y     = 32'h5000_2004;
    localparam logic [31:0] ADDR_DELAY_Z     = 32'h5000_2008;
    localparam logic [31:0] ADDR_AXI_CTRL    = 32'h5000_3000;
    // Upper 22 address bits shared by the four capture banks at 0x5000_4000..0x5000_43FF.
    localparam logic [21:0] CAPTURE_PAGE     = 22'h14_0010;

    localparam logic [2:0] MODE_INCR   = 3'b000;
    localparam logic [2:0] MODE_RANDOM = 3'b010;

    typedef logic [255:0] beat_t;
    typedef enum logic {GEN_IDLE, GEN_RUN} gen_state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Random mode sends the LFSR lanes; any other mode sends a running word count.
    function automatic beat_t make_beat(input logic [2:0] mode, input beat_t lanes,
                                        input logic [8:0] idx);
        beat_t b;
        b = lanes;
        if (mode != MODE_RANDOM) begin
            for (int k = 0; k < LANES; k++) begin
                b[32*k +: 32] = {20'd0, idx, 3'(k)};
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/axist_lfsr256.sv
// Eight independent 32-bit Galois LFSR lanes; lane k restarts from SEED^k on load.
module axist_lfsr256
    import axist_h2h_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1234_5678
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  advance,
    output beat_t state
);

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (rst || load) begin
                state[32*k +: 32] <= SEED ^ 32'(k);
            end else if (advance) begin
                state[32*k +: 32] <= lfsr_step(state[32*k +: 32]);
            end
        end
    end

endmodule

// File: rtl/axist_aib_h2h_ctrl.sv
// AXI-ST host-to-host loopback with pattern generator, checker and AVMM-lite registers.
// Optional AXIST_ERR_INJECT_EN adds TX_PKT_CTRL[12], which corrupts bit 0 of beat 5 in the link.
module axist_aib_h2h_ctrl
    import axist_h2h_pkg::*;
#(
    parameter int          DATAWIDTH = 256,
    parameter int          LINK_LAT  = 4,
    parameter logic [31:0] SEED      = 32'h1234_5678
) (
    input  logic                 mgmt_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_wr_addr,
    input  logic [31:0]          i_wrdata,
    input  logic                 i_wren,
    input  logic                 i_rden,
    output logic [31:0]          o_master_readdata,
    output logic                 o_master_readdatavalid,
    output logic                 o_master_waitreq,
    output logic [DATAWIDTH-1:0] o_tb_patdout,
    output logic                 o_tb_axist_valid,
    output logic                 o_tb_axist_ready,
    output logic                 tx_online,
    output logic                 rx_online,
    output logic                 test_done
);

    logic        wren_q, rden_q, wr_pulse, rd_pulse;
    logic [31:0] rd_addr, rd_mux;
    logic [31:0] delay_x, delay_y, delay_z, link_cnt;
    logic        axi_rst, link_armed, link_ready;
    logic [3:0]  linkup;
    logic [2:0]  mode;
    logic [7:0]  beat_cnt_m1;
    logic [8:0]  last_idx, tx_idx, rx_idx;
    logic        err_inject;
    logic        sts_pass, sts_complete, sts_align, test_active;
    logic        start_ok, tx_fire, rx_fire;
    gen_state_t  gen_state, gen_next;
    beat_t       gen_lfsr, chk_lfsr, tx_beat, chk_beat, link_data, rx_data, bank;
    beat_t       dout_first, dout_last, din_first, din_last;
    logic [LINK_LAT-1:0] pipe_valid;
    beat_t       pipe_data [LINK_LAT];

`ifndef AXIST_ERR_INJECT_EN
    assign err_inject = 1'b0;
`endif

    assign wr_pulse   = i_wren & ~wren_q;
    assign rd_pulse   = i_rden & ~rden_q;
    assign last_idx   = {1'b0, beat_cnt_m1};
    assign link_ready = (linkup == 4'hF);
    assign start_ok   = wr_pulse && (i_wr_addr == ADDR_TX_PKT_CTRL) && i_wrdata[0]
                        && !test_active && !axi_rst;
    assign tx_fire    = o_tb_axist_valid && link_ready;
    assign rx_fire    = pipe_valid[LINK_LAT-1];
    assign rx_data    = pipe_data[LINK_LAT-1];
    assign tx_beat    = make_beat(mode, gen_lfsr, tx_idx);
    assign chk_beat   = make_beat(mode, chk_lfsr, rx_idx);

    assign o_tb_axist_ready = link_ready;
    assign tx_online        = linkup[1];
    assign rx_online        = linkup[3];
    assign test_done        = sts_complete;

    axist_lfsr256 #(.SEED(SEED)) u_gen_lfsr (
        .clk(mgmt_clk), .rst(i_rst), .load(start_ok || axi_rst),
        .advance(tx_fire), .state(gen_lfsr)
    );

    axist_lfsr256 #(.SEED(SEED)) u_chk_lfsr (
        .clk(mgmt_clk), .rst(i_rst), .load(start_ok || axi_rst),
        .advance(rx_fire), .state(chk_lfsr)
    );

    always_ff @(posedge mgmt_clk) begin
        if (i_rst) begin
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            delay_x     <= '0;
            delay_y     <= '0;
            delay_z     <= '0;
            axi_rst     <= 1'b0;
            mode        <= MODE_INCR;
            beat_cnt_m1 <= '0;
`ifdef AXIST_ERR_INJECT_EN
            err_inject  <= 1'b0;
`endif
        end else begin
            wren_q <= i_wren;
            rden_q <= i_rden;
            if (wr_pulse) begin
                case (i_wr_addr)
                    ADDR_TX_PKT_CTRL: if (!test_active) begin
                        mode        <= i_wrdata[3:1];
                        beat_cnt_m1 <= i_wrdata[11:4];
`ifdef AXIST_ERR_INJECT_EN
                        err_inject  <= i_wrdata[12];
`endif
                    end
                    ADDR_DELAY_X:  delay_x <= i_wrdata;
                    ADDR_DELAY_Y:  delay_y <= i_wrdata;
                    ADDR_DELAY_Z:  delay_z <= i_wrdata;
                    ADDR_AXI_CTRL: axi_rst <= i_wrdata[0];
                    default: ;
                endcase
            end
        end
    end

    // The link only comes up after a soft-reset pulse has been seen since power-on reset.
    always_ff @(posedge mgmt_clk) begin
        if (i_rst) begin
            link_armed <= 1'b0;
            link_cnt   <= '0;
        end else if (axi_rst) begin
            link_armed <= 1'b1;
            link_cnt   <= '0;
        end else if (link_cnt != '1) begin
            link_cnt <= link_cnt + 32'd1;
        end
    end

    always_comb begin
        linkup = '0;
        if (link_armed && !axi_rst) begin
            linkup[0] = link_cnt >= delay_x;
            linkup[1] = link_cnt >= delay_x + delay_y;
            linkup[2] = link_cnt >= delay_x + delay_y + delay_z;
            linkup[3] = linkup[2];
        end
    end

    always_ff @(posedge mgmt_clk) begin
        if (i_rst) gen_state <= GEN_IDLE;
        else       gen_state <= gen_next;
    end

    always_comb begin
        gen_next = gen_state;
        case (gen_state)
            GEN_IDLE: if (start_ok) gen_next = GEN_RUN;
            GEN_RUN:  if (axi_rst || (tx_fire && tx_idx == last_idx)) gen_next = GEN_IDLE;
            default:  gen_next = GEN_IDLE;
        endcase
    end

    always_comb begin
        o_tb_axist_valid = (gen_state == GEN_RUN);
        o_tb_patdout     = o_tb_axist_valid ? tx_beat : '0;
    end

    always_ff @(posedge mgmt_clk) begin
        if (i_rst) begin
            tx_idx     <= '0;
            dout_first <= '0;
            dout_last  <= '0;
        end else if (start_ok) begin
            tx_idx <= '0;
        end else if (tx_fire) begin
            if (tx_idx == 9'd0)     dout_first <= tx_beat;
            if (tx_idx == last_idx) dout_last  <= tx_beat;
            tx_idx <= tx_idx + 9'd1;
        end
    end

    always_comb begin
        link_data = tx_beat;
        if (err_inject && tx_idx == 9'd5) link_data[0] = ~tx_beat[0];
    end

    always_ff @(posedge mgmt_clk) begin
        if (i_rst || axi_rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= tx_fire;
            for (int i = 1; i < LINK_LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
        pipe_data[0] <= link_data;
        for (int i = 1; i < LINK_LAT; i++) pipe_data[i] <= pipe_data[i-1];
    end

    // A soft reset aborts the test but leaves complete low, so software sees an unfinished run.
    always_ff @(posedge mgmt_clk) begin
        if (i_rst) begin
            sts_pass     <= 1'b0;
            sts_complete <= 1'b0;
            sts_align    <= 1'b0;
            test_active  <= 1'b0;
            rx_idx       <= '0;
            din_first    <= '0;
            din_last     <= '0;
        end else if (axi_rst) begin
            test_active <= 1'b0;
            rx_idx      <= '0;
        end else if (start_ok) begin
            sts_pass     <= 1'b1;
            sts_complete <= 1'b0;
            sts_align    <= link_ready;
            test_active  <= 1'b1;
            rx_idx       <= '0;
        end else if (rx_fire) begin
            if (rx_data != chk_beat) sts_pass <= 1'b0;
            if (rx_idx == 9'd0) din_first <= rx_data;
            if (rx_idx == last_idx) begin
                din_last     <= rx_data;
                sts_complete <= 1'b1;
                test_active  <= 1'b0;
            end
            rx_idx <= rx_idx + 9'd1;
        end
    end

    always_comb begin
        case (rd_addr[9:8])
            2'd0:    bank = dout_first;
            2'd1:    bank = dout_last;
            2'd2:    bank = din_first;
            default: bank = din_last;
        endcase
        rd_mux = '0;
        case (rd_addr)
            ADDR_TX_PKT_CTRL: rd_mux = {19'd0, err_inject, beat_cnt_m1, mode, 1'b0};
            ADDR_RX_CKR_STS:  rd_mux = {28'd0, sts_align, 1'b0, sts_complete, sts_pass};
            ADDR_LINKUP:      rd_mux = {28'd0, linkup};
            ADDR_DELAY_X:     rd_mux = delay_x;
            ADDR_DELAY_Y:     rd_mux = delay_y;
            ADDR_DELAY_Z:     rd_mux = delay_z;
            ADDR_AXI_CTRL:    rd_mux = {31'd0, axi_rst};
            default: begin
                if (rd_addr[31:10] == CAPTURE_PAGE && rd_addr[7:5] == 3'd0
                    && rd_addr[1:0] == 2'd0) begin
                    rd_mux = bank[{rd_addr[4:2], 5'd0} +: 32];
                end
            end
        endcase
    end

    always_ff @(posedge mgmt_clk) begin
        if (i_rst) begin
            rd_addr                <= '0;
            o_master_waitreq       <= 1'b0;
            o_master_readdatavalid <= 1'b0;
            o_master_readdata      <= '0;
        end else begin
            o_master_readdatavalid <= 1'b0;
            if (rd_pulse) begin
                o_master_waitreq <= 1'b1;
                rd_addr          <= i_wr_addr;
            end else if (o_master_waitreq) begin
                o_master_waitreq       <= 1'b0;
                o_master_readdatavalid <= 1'b1;
                o_master_readdata      <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_axist_aib_h2h_ctrl.sv
// Directed self-checking bench for axist_aib_h2h_ctrl: reset, link bring-up, test runs,
// stalled start, optional error injection (AXIST_ERR_INJECT_EN) and soft-reset abort.
module tb_axist_aib_h2h_ctrl;

    localparam logic [31:0] SEED         = 32'h1234_5678;
    localparam logic [31:0] A_TX         = 32'h5000_1000;
    localparam logic [31:0] A_STS        = 32'h5000_1004;
    localparam logic [31:0] A_LINKUP     = 32'h5000_1008;
    localparam logic [31:0] A_DX         = 32'h5000_2000;
    localparam logic [31:0] A_DY         = 32'h5000_2004;
    localparam logic [31:0] A_DZ         = 32'h5000_2008;
    localparam logic [31:0] A_AXI        = 32'h5000_3000;
    localparam logic [31:0] A_DOUT_FIRST = 32'h5000_4000;
    localparam logic [31:0] A_DOUT_LAST  = 32'h5000_4100;
    localparam logic [31:0] A_DIN_FIRST  = 32'h5000_4200;
    localparam logic [31:0] A_DIN_LAST   = 32'h5000_4300;

    logic         clk = 1'b0;
    logic         rst, wren, rden;
    logic [31:0]  wr_addr, wrdata, rdata;
    logic         rdvalid, waitreq, valid, ready, tx_online, rx_online, test_done;
    logic [255:0] patdout;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    axist_aib_h2h_ctrl dut (
        .mgmt_clk(clk), .i_rst(rst), .i_wr_addr(wr_addr), .i_wrdata(wrdata),
        .i_wren(wren), .i_rden(rden), .o_master_readdata(rdata),
        .o_master_readdatavalid(rdvalid), .o_master_waitreq(waitreq),
        .o_tb_patdout(patdout), .o_tb_axist_valid(valid), .o_tb_axist_ready(ready),
        .tx_online(tx_online), .rx_online(rx_online), .test_done(test_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_lane(input int lane, input int steps);
        logic [31:0] s;
        s = SEED ^ 32'(lane);
        for (int i = 0; i < steps; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk); wr_addr = addr; wrdata = data; wren = 1'b1;
        @(negedge clk); wren = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic wait_seen);
        bit got;
        got = 0;
        data = 32'hDEAD_BEEF;
        @(negedge clk); wr_addr = addr; rden = 1'b1;
        @(negedge clk); wait_seen = waitreq; rden = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (rdvalid) begin data = rdata; got = 1; end
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL read_timeout addr=%h: no readdatavalid, expected within 8 cycles", addr);
        end
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!test_done && n < max_cycles) begin @(negedge clk); n++; end
        checks++;
        if (test_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: test_done=%b after %0d cycles, expected 1", name, test_done, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic w;
        rst = 1'b1; wren = 1'b0; rden = 1'b0; wr_addr = '0; wrdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({waitreq, rdvalid, valid, ready, tx_online, rx_online, test_done} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {waitreq, rdvalid, valid, ready, tx_online, rx_online, test_done});
        end
        checks++;
        if (patdout !== '0) begin errors++; $display("[TB] FAIL reset_patdout: got %h expected 0", patdout); end
        do_read(A_LINKUP, d, w);
        checks++;
        if (w !== 1'b1) begin errors++; $display("[TB] FAIL read_waitreq: got %b expected 1", w); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_linkup: got %h expected 0", d); end
        checks++;
        if (waitreq !== 1'b0) begin errors++; $display("[TB] FAIL idle_waitreq: got %b expected 0", waitreq); end
        do_read(32'h5000_0000, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_reset: got %h expected 0", d); end
    endtask

    task automatic test_linkup();
        logic [31:0] d;
        logic w;
        int t0;
        do_write(A_DX, 32'd12);
        do_write(A_DY, 32'd32);
        do_write(A_DZ, 32'd6000);
        do_write(A_AXI, 32'd1);
        do_write(A_AXI, 32'd0);
        t0 = cyc;
        do_read(A_LINKUP, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL linkup_early: got %h expected 0", d); end
        while (cyc < t0 + 20) @(negedge clk);
        do_read(A_LINKUP, d, w);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL linkup_x: got %h expected 1", d); end
        while (cyc < t0 + 43) @(negedge clk);
        checks++;
        if (tx_online !== 1'b0) begin errors++; $display("[TB] FAIL tx_online_43: got %b expected 0", tx_online); end
        @(negedge clk);
        checks++;
        if (tx_online !== 1'b1) begin errors++; $display("[TB] FAIL tx_online_44: got %b expected 1", tx_online); end
        do_read(A_LINKUP, d, w);
        checks++;
        if (d !== 32'h3) begin errors++; $display("[TB] FAIL linkup_xy: got %h expected 3", d); end
        while (cyc < t0 + 6043) @(negedge clk);
        checks++;
        if (rx_online !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("[TB] FAIL rx_online_6043: got rx=%b rdy=%b expected 0 0", rx_online, ready);
        end
        @(negedge clk);
        checks++;
        if (rx_online !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rx_online_6044: got rx=%b rdy=%b expected 1 1", rx_online, ready);
        end
        do_write(A_LINKUP, 32'h0);
        do_read(A_LINKUP, d, w);
        checks++;
        if (d !== 32'hF) begin errors++; $display("[TB] FAIL linkup_full: got %h expected f", d); end
    endtask

    task automatic test_random_run();
        logic [31:0] d;
        logic w;
        do_write(A_TX, 32'hFF5);
        checks++;
        if (valid !== 1'b1 || patdout[31:0] !== SEED || patdout[255:224] !== (SEED ^ 32'd7)) begin
            errors++;
            $display("[TB] FAIL first_beat: got valid=%b w0=%h w7=%h expected 1 %h %h",
                     valid, patdout[31:0], patdout[255:224], SEED, SEED ^ 32'd7);
        end
        wait_done(1000, "random_done");
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_after_last: got %b expected 0", valid); end
        do_write(A_STS, 32'h0);
        do_read(A_STS, d, w);
        checks++;
        if (d !== 32'hB) begin errors++; $display("[TB] FAIL random_status: got %h expected b", d); end
        do_read(32'h5000_1010, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_after: got %h expected 0", d); end
        for (int k = 0; k < 8; k++) begin
            do_read(A_DOUT_FIRST + 32'(4*k), d, w);
            checks++;
            if (d !== (SEED ^ 32'(k))) begin
                errors++; $display("[TB] FAIL dout_first[%0d]: got %h expected %h", k, d, SEED ^ 32'(k));
            end
            do_read(A_DIN_FIRST + 32'(4*k), d, w);
            checks++;
            if (d !== (SEED ^ 32'(k))) begin
                errors++; $display("[TB] FAIL din_first[%0d]: got %h expected %h", k, d, SEED ^ 32'(k));
            end
        end
        for (int k = 0; k < 8; k += 7) begin
            do_read(A_DOUT_LAST + 32'(4*k), d, w);
            checks++;
            if (d !== ref_lane(k, 255)) begin
                errors++; $display("[TB] FAIL dout_last[%0d]: got %h expected %h", k, d, ref_lane(k, 255));
            end
            do_read(A_DIN_LAST + 32'(4*k), d, w);
            checks++;
            if (d !== ref_lane(k, 255)) begin
                errors++; $display("[TB] FAIL din_last[%0d]: got %h expected %h", k, d, ref_lane(k, 255));
            end
        end
    endtask

    task automatic test_incrementing();
        logic [31:0] d;
        logic w;
        do_write(A_TX, 32'h31);
        wait_done(200, "incr_done");
        do_read(A_STS, d, w);
        checks++;
        if (d !== 32'hB) begin errors++; $display("[TB] FAIL incr_status: got %h expected b", d); end
        do_read(A_DIN_FIRST + 32'h14, d, w);
        checks++;
        if (d !== 32'd5) begin errors++; $display("[TB] FAIL incr_din_first5: got %h expected 5", d); end
        do_read(A_DIN_LAST, d, w);
        checks++;
        if (d !== 32'd24) begin errors++; $display("[TB] FAIL incr_din_last0: got %h expected 18", d); end
        do_read(A_DOUT_LAST + 32'h1C, d, w);
        checks++;
        if (d !== 32'd31) begin errors++; $display("[TB] FAIL incr_dout_last7: got %h expected 1f", d); end
    endtask

    task automatic test_start_before_linkup();
        logic [31:0] d;
        logic w;
        do_write(A_DZ, 32'd100);
        do_write(A_AXI, 32'd1);
        do_write(A_AXI, 32'd0);
        do_write(A_TX, 32'hFF5);
        repeat (20) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || ready !== 1'b0 || test_done !== 1'b0 || patdout[31:0] !== SEED) begin
            errors++;
            $display("[TB] FAIL stall: got valid=%b ready=%b done=%b w0=%h expected 1 0 0 %h",
                     valid, ready, test_done, patdout[31:0], SEED);
        end
        wait_done(1500, "stalled_done");
        do_read(A_STS, d, w);
        checks++;
        if (d !== 32'h3) begin errors++; $display("[TB] FAIL stalled_status: got %h expected 3", d); end
        do_read(A_DIN_LAST + 32'h1C, d, w);
        checks++;
        if (d !== ref_lane(7, 255)) begin
            errors++; $display("[TB] FAIL stalled_din_last7: got %h expected %h", d, ref_lane(7, 255));
        end
    endtask

    task automatic test_err_inject();
        logic [31:0] d;
        logic w;
        do_write(A_TX, 32'h1FF4);
        do_read(A_TX, d, w);
        checks++;
`ifdef AXIST_ERR_INJECT_EN
        if (d !== 32'h1FF4) begin errors++; $display("[TB] FAIL tx_ctrl_readback: got %h expected 1ff4", d); end
        do_write(A_TX, 32'h1FF5);
        wait_done(1000, "inject_done");
        do_read(A_STS, d, w);
        checks++;
        if (d !== 32'hA) begin errors++; $display("[TB] FAIL inject_status: got %h expected a", d); end
        do_read(A_DIN_LAST, d, w);
        checks++;
        if (d !== ref_lane(0, 255)) begin
            errors++; $display("[TB] FAIL inject_din_last0: got %h expected %h", d, ref_lane(0, 255));
        end
`else
        if (d !== 32'h0FF4) begin errors++; $display("[TB] FAIL tx_ctrl_readback: got %h expected ff4", d); end
`endif
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic w;
        do_write(A_TX, 32'hFF5);
        repeat (50) @(negedge clk);
        do_write(A_AXI, 32'd1);
        @(negedge clk);
        checks++;
        if ({valid, ready, tx_online, rx_online, test_done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL abort_flags: got %b expected 00000", {valid, ready, tx_online, rx_online, test_done});
        end
        repeat (10) @(negedge clk);
        do_read(A_STS, d, w);
        checks++;
        if (d !== 32'h9) begin errors++; $display("[TB] FAIL abort_status: got %h expected 9", d); end
        do_read(A_LINKUP, d, w);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL abort_linkup: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_linkup();
        test_random_run();
        test_incrementing();
        test_start_before_linkup();
        test_err_inject();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
